mantissa_square_unit: RTL and testbench
=======================================

Name: mantissa_square_unit

Overview:
- Iterative shift-add squarer for LAMP normalized mantissas; the inverse operation of the square-root unit, using the same do/valid handshake.
- Takes a 1.f mantissa (hidden bit included) and produces the normalized square.
- Outputs a guard bit, a sticky bit and an exponent-increment flag for downstream rounding and exponent logic.
- Used by the FPU for x² and as a self-check path for square-root results.

Parameters:
- F_DW, default 7 (LAMP_FLOAT_F_DW from lampFPU_pkg), fraction width.
- Mantissa width is W = 1+F_DW (8 by default); product width is 2W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- doSquare_i  in  1  request; sampled only in IDLE.
- s_i  in  W  operand mantissa 1.f; MSB is the hidden bit.
- busy_o  out  1  high in BUSY and DONE.
- valid_o  out  1  one-cycle pulse: result is valid.
- res_o  out  W  normalized squared mantissa.
- guard_o  out  1  first bit below the res_o LSB.
- sticky_o  out  1  OR of all bits below guard.
- exp_inc_o  out  1  product was ≥ 2.0; caller adds 1 to the exponent.

Behaviour:
- Reset (rst=0, async, any state): state=IDLE. Counter, multiplicand, multiplier and accumulator cleared. valid_o=0, busy_o=0, res_o=0, guard_o=0, sticky_o=0, exp_inc_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a clock edge with doSquare_i=1: latch s_i into the multiplicand (2W wide, zero-extended) and the multiplier (W wide).
  - Clear the accumulator, set cnt=0, go to BUSY.
  - doSquare_i=0: stay in IDLE.
- BUSY, one multiplier bit per cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand.
  - Multiplicand <<= 1, multiplier >>= 1, cnt++.
  - The edge that processes bit W-1 (cnt==W-1) goes to DONE and registers the outputs.
- Output normalization (P = final 2W-bit product):
  - If P[2W-1]=1: res_o=P[2W-1:W], guard_o=P[W-1], sticky_o=|P[W-2:0], exp_inc_o=1.
  - Else: res_o=P[2W-2:W-1], guard_o=P[W-2], sticky_o=|P[W-3:0], exp_inc_o=0.
  - No further normalization. Denormal or zero inputs pass through unnormalized; s_i=0 gives all zeros.
- DONE:
  - valid_o=1 for exactly this cycle; next edge goes to IDLE.
  - doSquare_i during BUSY or DONE is ignored.
  - If doSquare_i is still high in the following IDLE cycle, a new operation starts there (level-sensitive request). Minimum issue interval is W+2 cycles.
- Latency: acceptance edge, then W BUSY edges; valid_o is high during the cycle after the W-th BUSY edge (W+1 cycles after acceptance; 9 for W=8).
- res_o, guard_o, sticky_o and exp_inc_o hold their values until the next DONE or reset.
- Changes to s_i after acceptance have no effect.
- Reset asserted mid-operation aborts the operation; no valid_o pulse follows.
- Accumulator width is 2W; the max product (2^W-1)² fits, so no overflow is possible.

Test Plan:
- Reset held 2 cycles with doSquare_i=1 -> all outputs 0, busy_o=0; no start until rst=1.
- s_i=8'b10000000 (1.0) -> after 9 cycles valid_o=1, res_o=8'b10000000, guard=0, sticky=0, exp_inc=0.
- s_i=8'b11011000 -> P=0xB640; res_o=8'b10110110, guard=0, sticky=1, exp_inc=1.
- s_i=8'b11111111 -> P=0xFE01; res_o=8'b11111110, guard=0, sticky=1, exp_inc=1.
- s_i=8'b10110101 -> P=0x7FF9; res_o=8'b11111111, guard=1, sticky=1, exp_inc=0.
- Two boundary cases:
  - doSquare_i held high continuously -> valid_o pulses exactly every 10 cycles (W+2), one cycle each.
  - rst pulsed low at BUSY cycle 4 -> immediate IDLE, outputs 0, no valid_o pulse.

Source files
------------

// File: rtl/mantissa_square_unit.sv
// Iterative shift-add squarer for normalized 1.f mantissas.
// Returns the normalized square plus guard, sticky and exponent-increment flags.
module mantissa_square_unit #(
    parameter int F_DW = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            doSquare_i,
    input  logic [F_DW:0]   s_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [F_DW:0]   res_o,
    output logic            guard_o,
    output logic            sticky_o,
    output logic            exp_inc_o,
    output logic [1:0]      dbg_state_o
);

    localparam int W  = F_DW + 1;
    localparam int PW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // Handshake: doSquare_i is a level request sampled only in IDLE; valid_o
    // is a one-cycle pulse in DONE, and busy_o is high in BUSY and DONE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_mcand;
    logic [W-1:0]    r_mplier;
    logic [PW-1:0]   r_acc;
    logic [W-1:0]    r_res;
    logic            r_guard;
    logic            r_sticky;
    logic            r_exp_inc;

    logic            w_last;
    logic [PW-1:0]   w_acc_sum;
    logic            w_norm_hi;
    logic [W-1:0]    w_res;
    logic            w_guard;
    logic            w_sticky;

    assign w_last    = (r_state == S_BUSY) && (r_cnt == CW'(W - 1));
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});

    // Product >= 2.0 lands in the top bit; otherwise take one bit lower.
    assign w_norm_hi = w_acc_sum[PW-1];
    assign w_res     = w_norm_hi ? w_acc_sum[PW-1:W] : w_acc_sum[PW-2:W-1];
    assign w_guard   = w_norm_hi ? w_acc_sum[W-1]    : w_acc_sum[W-2];
    assign w_sticky  = w_norm_hi ? (|w_acc_sum[W-2:0]) : (|w_acc_sum[W-3:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (doSquare_i) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (doSquare_i) begin
                        r_mcand  <= {{W{1'b0}}, s_i};
                        r_mplier <= s_i;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers are loaded only on the final BUSY edge and hold afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res     <= '0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_exp_inc <= 1'b0;
        end else if (w_last) begin
            r_res     <= w_res;
            r_guard   <= w_guard;
            r_sticky  <= w_sticky;
            r_exp_inc <= w_norm_hi;
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign valid_o     = (r_state == S_DONE);
    assign res_o       = r_res;
    assign guard_o     = r_guard;
    assign sticky_o    = r_sticky;
    assign exp_inc_o   = r_exp_inc;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mantissa_square_unit.sv
// Bench for mantissa_square_unit: directed and random squares checked by a
// queue scoreboard against an arithmetic model, plus reset and back-to-back cases.
module tb_mantissa_square_unit;

    localparam int F_DW = 7;
    localparam int W    = F_DW + 1;

    logic           clk;
    logic           rst;
    logic           doSquare_i;
    logic [W-1:0]   s_i;
    logic           busy_o;
    logic           valid_o;
    logic [W-1:0]   res_o;
    logic           guard_o;
    logic           sticky_o;
    logic           exp_inc_o;
    logic [1:0]     dbg_state_o;

    logic [W+2:0]   exp_q[$];
    logic [W+2:0]   last_exp;
    int             checks;
    int             errors;
    int             cyc;
    int             last_valid_cyc;
    bit             held_mode;
    bit             prev_valid;

    mantissa_square_unit #(.F_DW(F_DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .doSquare_i  (doSquare_i),
        .s_i         (s_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .res_o       (res_o),
        .guard_o     (guard_o),
        .sticky_o    (sticky_o),
        .exp_inc_o   (exp_inc_o),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Square with plain integer arithmetic, then pick the normalization window.
    function automatic logic [W+2:0] model(input logic [W-1:0] s);
        int unsigned p;
        int unsigned sh;
        logic [W-1:0] r;
        logic g, st, e;
        p  = int'(s) * int'(s);
        e  = (p >= (32'd1 << (2 * W - 1)));
        sh = e ? W : W - 1;
        r  = W'(p >> sh);
        g  = ((p >> (sh - 1)) & 1) != 0;
        st = (p % (32'd1 << (sh - 1))) != 0;
        return {r, g, st, e};
    endfunction

    // Monitor: every valid_o pulse consumes one expected result.
    always @(negedge clk) begin
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got res %0h with empty queue (t=%0t)", res_o, $time);
            end else begin
                last_exp = exp_q.pop_front();
                check("result", {res_o, guard_o, sticky_o, exp_inc_o}, last_exp);
            end
            check("valid_width", prev_valid, 1'b0);
            if (held_mode && last_valid_cyc >= 0) begin
                check("valid_period", cyc - last_valid_cyc, 10);
            end
            last_valid_cyc = cyc;
        end
        prev_valid = valid_o;
    end

    task automatic run_op(input logic [W-1:0] s, input logic [W+2:0] exp);
        int n;
        @(negedge clk);
        doSquare_i = 1'b1;
        s_i        = s;
        @(posedge clk);
        exp_q.push_back(exp);
        n = 1;
        @(negedge clk);
        doSquare_i = 1'b0;
        s_i        = W'($urandom);
        while (!valid_o && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", n, 9);
        repeat (3) @(negedge clk);
        check("hold", {res_o, guard_o, sticky_o, exp_inc_o}, exp);
        check("idle_after", {busy_o, valid_o}, 2'b00);
    endtask

    initial begin
        logic [W-1:0] v;
        checks = 0;
        errors = 0;
        cyc = 0;
        last_valid_cyc = -1;
        held_mode = 1'b0;
        prev_valid = 1'b0;
        rst = 1'b0;
        doSquare_i = 1'b1;
        s_i = 8'hFF;

        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", {busy_o, valid_o, res_o, guard_o, sticky_o, exp_inc_o}, '0);
        end
        doSquare_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {busy_o, valid_o}, 2'b00);

        run_op(8'b10000000, {8'b10000000, 1'b0, 1'b0, 1'b0});
        run_op(8'b11011000, {8'b10110110, 1'b0, 1'b1, 1'b1});
        run_op(8'b11111111, {8'b11111110, 1'b0, 1'b1, 1'b1});
        run_op(8'b10110101, {8'b11111111, 1'b1, 1'b1, 1'b0});
        run_op(8'b00000000, {8'b00000000, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 20; i++) begin
            v = W'($urandom_range(0, 255));
            run_op(v, model(v));
        end

        // Request held high: accepts every 10 edges; s_i churns every cycle.
        held_mode = 1'b1;
        last_valid_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            doSquare_i = 1'b1;
            s_i = W'($urandom);
            v = s_i;
            @(posedge clk);
            if (i % 10 == 0) exp_q.push_back(model(v));
        end
        @(negedge clk);
        doSquare_i = 1'b0;
        repeat (12) @(negedge clk);
        held_mode = 1'b0;
        check("held_drained", exp_q.size(), 0);

        // Reset mid-operation: abort with no valid pulse.
        @(negedge clk);
        doSquare_i = 1'b1;
        s_i = 8'b11011000;
        @(posedge clk);
        @(negedge clk);
        doSquare_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("busy_before_abort", busy_o, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_outputs", {busy_o, valid_o, res_o, guard_o, sticky_o, exp_inc_o}, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_idle", {busy_o, valid_o}, 2'b00);

        v = W'($urandom_range(128, 255));
        run_op(v, model(v));

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
